// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg
// Shared definitions for the MTM ALU request deserializer: operation codes,
// error-flag bit positions, frame/packet length constants, the frame FSM
// state type and the CRC-4 helper also used by the tester.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TYPE,
        S_DATA,
        S_STOP
    } frame_state_t;

    // Bit positions inside err_flags = {ERR_DATA, ERR_CRC, ERR_OP}
    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    localparam int          DATA_BITS    = 8;
    localparam logic [3:0]  PKT_FRAMES   = 4'd8;   // data frames per packet
    localparam logic [3:0]  CNT_SAT      = 4'd9;   // data-frame counter ceiling
    localparam int          CRC_MSG_BITS = 68;     // {B, A, 1'b1, op}

    // CRC-4, polynomial x^4+x+1, init 0, message processed MSB first.
    function automatic logic [3:0] crc4(input logic [CRC_MSG_BITS-1:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = CRC_MSG_BITS - 1; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mtm_alu_rx_frame.sv
// mtm_alu_rx_frame
// Bit-level receiver for one 11-bit frame: start 0, type, 8 data MSB first,
// stop 1. frame_ok / frame_err are combinational and valid only during the
// cycle in which the stop bit is sampled; frame_type and frame_byte are
// stable during that cycle.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   sin          serial line, idle high
//   frame_type   0 = data frame, 1 = CTL frame
//   frame_byte   received byte
//   frame_ok     stop bit sampled as 1
//   frame_err    stop bit sampled as 0
//
// state  | meaning
// S_IDLE | waiting for a start bit (sin = 0)
// S_TYPE | sampling the type bit
// S_DATA | shifting in 8 data bits
// S_STOP | sampling the stop bit, reporting the frame
module mtm_alu_rx_frame
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic       frame_type,
    output logic [7:0] frame_byte,
    output logic       frame_ok,
    output logic       frame_err
);

    frame_state_t state, state_next;
    logic [2:0]   bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            frame_type <= 1'b0;
            frame_byte <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                S_TYPE: begin
                    frame_type <= sin;
                    bit_cnt    <= 3'd0;
                end
                S_DATA: begin
                    frame_byte <= {frame_byte[6:0], sin};
                    bit_cnt    <= bit_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        frame_ok   = 1'b0;
        frame_err  = 1'b0;
        case (state)
            S_IDLE: if (!sin) state_next = S_TYPE;
            S_TYPE: state_next = S_DATA;
            S_DATA: if (bit_cnt == 3'd7) state_next = S_STOP;
            S_STOP: begin
                state_next = S_IDLE;
                frame_ok   = sin;
                frame_err  = !sin;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer
// Assembles packets of 8 data frames (B then A, MSB byte first) followed by
// one CTL frame {1'b0, op, crc}, checks frame count, CRC and opcode, and
// reports either an accepted packet or an error one cycle after the CTL
// stop bit.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sin        serial request line, idle high
//   a_out      operand A of last accepted packet
//   b_out      operand B of last accepted packet
//   op_out     operation of last accepted packet
//   valid_out  one-cycle pulse, packet accepted
//   err_out    one-cycle pulse, packet rejected
//   err_flags  {ERR_DATA, ERR_CRC, ERR_OP} of last rejection, cleared on accept
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [2:0]  op_out,
    output logic        valid_out,
    output logic        err_out,
    output logic [2:0]  err_flags
);

    logic        frame_type;
    logic [7:0]  frame_byte;
    logic        frame_ok;
    logic        frame_err;

    logic [63:0] shift_q;
    logic [3:0]  frame_cnt;

    logic [2:0]  ctl_op;
    logic [3:0]  ctl_crc;
    logic [3:0]  calc_crc;
    logic [2:0]  err_next;
    logic        ctl_done;
    logic        pkt_ok;
    logic        pkt_err;

    mtm_alu_rx_frame u_rx_frame (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .frame_type (frame_type),
        .frame_byte (frame_byte),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err)
    );

    // CRC is evaluated combinationally on the assembled packet while the
    // CTL stop bit is being sampled.
    always_comb begin
        ctl_op   = frame_byte[6:4];
        ctl_crc  = frame_byte[3:0];
        calc_crc = crc4({shift_q, 1'b1, ctl_op});
        ctl_done = frame_ok && frame_type;
        err_next = 3'b000;
        if (frame_err) begin
            err_next[ERR_DATA] = 1'b1;
        end else if (ctl_done) begin
            if (frame_cnt != PKT_FRAMES)
                err_next[ERR_DATA] = 1'b1;
            else if (calc_crc != ctl_crc)
                err_next[ERR_CRC] = 1'b1;
            else if (frame_byte[7] || !is_legal_op(ctl_op))
                err_next[ERR_OP] = 1'b1;
        end
        pkt_err = |err_next;
        pkt_ok  = ctl_done && !pkt_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= 64'd0;
            frame_cnt <= 4'd0;
            a_out     <= 32'd0;
            b_out     <= 32'd0;
            op_out    <= 3'd0;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            err_flags <= 3'd0;
        end else begin
            valid_out <= pkt_ok;
            err_out   <= pkt_err;

            if (pkt_ok) begin
                b_out     <= shift_q[63:32];
                a_out     <= shift_q[31:0];
                op_out    <= ctl_op;
                err_flags <= 3'd0;
            end
            if (pkt_err)
                err_flags <= err_next;

            if (frame_ok && !frame_type) begin
                shift_q <= {shift_q[55:0], frame_byte};
                if (frame_cnt != CNT_SAT)
                    frame_cnt <= frame_cnt + 4'd1;
            end else if (frame_err || ctl_done) begin
                frame_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Bench for mtm_alu_deserializer: packet-level reference model, per-cycle
// compare on the falling edge, directed scenarios plus randomized packets.
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [2:0]  op_out;
    logic        valid_out;
    logic        err_out;
    logic [2:0]  err_flags;

    mtm_alu_deserializer dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .a_out     (a_out),
        .b_out     (b_out),
        .op_out    (op_out),
        .valid_out (valid_out),
        .err_out   (err_out),
        .err_flags (err_flags)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic        exp_valid = 1'b0;
    logic        exp_err   = 1'b0;
    logic [2:0]  exp_flags = 3'd0;
    logic [31:0] exp_a     = 32'd0;
    logic [31:0] exp_b     = 32'd0;
    logic [2:0]  exp_op    = 3'd0;
    logic [7:0]  mq[$];

    logic        check_en   = 1'b0;
    logic        in_reset   = 1'b0;
    logic        crc_pinned = 1'b0;
    int          pin_kind   = 0;
    int          n_vec      = 0;
    int          n_mis      = 0;

    // CRC as remainder of (msg * x^4) mod (x^4+x+1) by long division.
    function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic legal_op(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("valid_out", 32'(valid_out), 32'(exp_valid));
            chk("err_out",   32'(err_out),   32'(exp_err));
            chk("err_flags", 32'(err_flags), 32'(exp_flags));
            chk("a_out",     a_out,          exp_a);
            chk("b_out",     b_out,          exp_b);
            chk("op_out",    32'(op_out),    32'(exp_op));
            if (!crc_pinned) begin
                chk("model_crc_add_1_2", 32'(ref_crc(32'd2, 32'd1, 3'b100)), 32'hC);
                crc_pinned = 1'b1;
            end
            if (in_reset) begin
                chk("rst_a_zero",     a_out,            32'd0);
                chk("rst_flags_zero", 32'(err_flags),   32'd0);
                chk("rst_pulse_zero", 32'({valid_out, err_out}), 32'd0);
            end
            if (exp_valid || exp_err) begin
                case (pin_kind)
                    1: begin
                        chk("add_valid", 32'(valid_out), 32'd1);
                        chk("add_a",     a_out,          32'd1);
                        chk("add_b",     b_out,          32'd2);
                        chk("add_op",    32'(op_out),    32'd4);
                    end
                    2: begin
                        chk("crcerr_pulse", 32'(err_out),   32'd1);
                        chk("crcerr_flags", 32'(err_flags), 32'b010);
                        chk("crcerr_a",     a_out,          32'd1);
                        chk("crcerr_b",     b_out,          32'd2);
                    end
                    3: begin
                        chk("short_pulse", 32'(err_out),   32'd1);
                        chk("short_flags", 32'(err_flags), 32'b100);
                    end
                    4: begin
                        chk("operr_pulse", 32'(err_out),   32'd1);
                        chk("operr_flags", 32'(err_flags), 32'b001);
                    end
                    5: begin
                        chk("abort_pulse", 32'(err_out),   32'd1);
                        chk("abort_flags", 32'(err_flags), 32'b100);
                    end
                    6: begin
                        chk("sub_valid", 32'(valid_out), 32'd1);
                        chk("sub_op",    32'(op_out),    32'b101);
                        chk("sub_a",     a_out,          32'hFFFF_FFFF);
                        chk("sub_b",     b_out,          32'd0);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Drive one bit; it is sampled on the next rising edge. Pulses expected
    // from the previous sample end at that edge.
    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic model_frame(input logic typ, input logic [7:0] byt, input logic stop);
        logic [31:0] pb, pa;
        logic [2:0]  op;
        if (!stop) begin
            exp_err   = 1'b1;
            exp_flags = 3'b100;
            mq.delete();
        end else if (!typ) begin
            mq.push_back(byt);
            if (mq.size() > 9) void'(mq.pop_front());
        end else begin
            op = byt[6:4];
            if (mq.size() != 8) begin
                exp_err   = 1'b1;
                exp_flags = 3'b100;
            end else begin
                pb = {mq[0], mq[1], mq[2], mq[3]};
                pa = {mq[4], mq[5], mq[6], mq[7]};
                if (ref_crc(pb, pa, op) != byt[3:0]) begin
                    exp_err   = 1'b1;
                    exp_flags = 3'b010;
                end else if (byt[7] || !legal_op(op)) begin
                    exp_err   = 1'b1;
                    exp_flags = 3'b001;
                end else begin
                    exp_valid = 1'b1;
                    exp_flags = 3'b000;
                    exp_a     = pa;
                    exp_b     = pb;
                    exp_op    = op;
                end
            end
            mq.delete();
        end
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] byt, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(byt[i]);
        send_bit(stop);
        model_frame(typ, byt, stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // bad >= 0 forces a zero stop bit in that data frame and ends the packet.
    task automatic send_packet(input logic [31:0] b, input logic [31:0] a,
                               input logic [2:0] op, input logic [3:0] crcv,
                               input int nd, input int bad, input logic bit7,
                               input logic gaps);
        logic [63:0] pkt;
        logic [7:0]  byt;
        pkt = {b, a};
        for (int k = 0; k < nd; k++) begin
            byt = (k < 8) ? pkt[63 - 8*k -: 8] : 8'($urandom);
            send_frame(1'b0, byt, (k != bad));
            if (k == bad) return;
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        send_frame(1'b1, {bit7, op, crcv}, 1'b1);
    endtask

    task automatic do_reset();
        sin = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_flags = 3'd0;
        exp_a     = 32'd0;
        exp_b     = 32'd0;
        exp_op    = 3'd0;
        mq.delete();
        in_reset  = 1'b1;
        check_en  = 1'b1;
        @(posedge clk);
        #1;
        in_reset  = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        logic [3:0]  rcrc;
        logic [1:0]  r2;
        int          nd, bad, mode;
        logic        b7;

        sin = 1'b1;
        rst = 1'b1;
        do_reset();
        idle(3);

        // Accepted ADD packet, then the same with a corrupted CRC
        pin_kind = 1;
        send_packet(32'd2, 32'd1, 3'b100, ref_crc(32'd2, 32'd1, 3'b100), 8, -1, 1'b0, 1'b0);
        idle(2);
        pin_kind = 2;
        send_packet(32'd2, 32'd1, 3'b100, ref_crc(32'd2, 32'd1, 3'b100) ^ 4'h1, 8, -1, 1'b0, 1'b0);
        idle(2);

        // Seven data frames only, then a good back-to-back packet
        pin_kind = 3;
        send_packet(32'h1234_5678, 32'h9ABC_DEF0, 3'b000,
                    ref_crc(32'h1234_5678, 32'h9ABC_DEF0, 3'b000), 7, -1, 1'b0, 1'b0);
        pin_kind = 0;
        send_packet(32'hCAFE_F00D, 32'h0BAD_BEEF, 3'b001,
                    ref_crc(32'hCAFE_F00D, 32'h0BAD_BEEF, 3'b001), 8, -1, 1'b0, 1'b0);
        idle(1);

        // Illegal opcode with correct CRC
        pin_kind = 4;
        send_packet(32'h0000_00FF, 32'hFF00_0000, 3'b010,
                    ref_crc(32'h0000_00FF, 32'hFF00_0000, 3'b010), 8, -1, 1'b0, 1'b0);
        idle(1);

        // Stop bit 0 in the third data frame, then a good packet
        pin_kind = 5;
        send_packet(32'h1111_2222, 32'h3333_4444, 3'b101,
                    ref_crc(32'h1111_2222, 32'h3333_4444, 3'b101), 8, 2, 1'b0, 1'b0);
        idle(1);
        pin_kind = 0;
        send_packet(32'h5555_6666, 32'h7777_8888, 3'b101,
                    ref_crc(32'h5555_6666, 32'h7777_8888, 3'b101), 8, -1, 1'b0, 1'b0);
        idle(2);

        // Reset during the fifth data frame, then a SUB packet
        for (int k = 0; k < 4; k++) send_frame(1'b0, 8'(8'hA0 + k), 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset();
        idle(1);
        pin_kind = 6;
        send_packet(32'd0, 32'hFFFF_FFFF, 3'b101,
                    ref_crc(32'd0, 32'hFFFF_FFFF, 3'b101), 8, -1, 1'b0, 1'b0);
        idle(2);
        pin_kind = 0;

        // Randomized packets
        for (int p = 0; p < 120; p++) begin
            ra   = $urandom;
            rb   = $urandom;
            r2   = 2'($urandom_range(0, 3));
            rop  = {r2[1], 1'b0, r2[0]};
            mode = $urandom_range(0, 9);
            nd   = 8;
            bad  = -1;
            b7   = 1'b0;
            case (mode)
                0: nd  = $urandom_range(0, 7);
                1: nd  = $urandom_range(9, 10);
                2: ;
                3: bad = $urandom_range(0, 7);
                4: b7  = 1'b1;
                5: rop = 3'($urandom_range(0, 7));
                default: ;
            endcase
            rcrc = ref_crc(rb, ra, rop);
            if (mode == 2) rcrc = rcrc ^ 4'($urandom_range(1, 15));
            send_packet(rb, ra, rop, rcrc, nd, bad, b7, 1'b1);
            idle($urandom_range(0, 3));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
